peripheral_dpram_capture: RTL and testbench
===========================================

// Module: peripheral_dpram_capture
// PURPOSE
//  CPU-read side of a dual-port sample buffer. A hardware producer pushes 16-bit samples into the buffer (port A).
//  The J1/femtoRV bus drains them in order through a memory-mapped peripheral (port B).
//  Also provides status (occupancy, empty, full) and a sticky overflow flag.
//  Sits on the I/O bus next to the other peripherals, decoded by cs.
// PARAMETERS
//  AW      8   buffer address width; DEPTH = 2**AW words of 16 bits
// PORTS
//  clk       in   1   system clock; bus and capture sides share it
//  reset     in   1   reset, asynchronous, active-high
//  cs        in   1   peripheral select from bus decoder
//  rd        in   1   bus read strobe, qualified by cs
//  wr        in   1   bus write strobe, qualified by cs
//  addr      in   16  bus address; only addr[2:1] decoded
//  d_in      in   16  bus write data
//  d_out     out  16  bus read data, registered
//  cap_valid in   1   producer has a sample this cycle; single-cycle push, no back-pressure
//  cap_data  in   16  sample word
//  irq       out  1   high while count >= CTRL.thresh and CTRL.en
// BEHAVIOUR
//  Register map (addr[2:1]):
//   0 DATA   R: pop head word. W: ignored.
//   1 STATUS R: {ovf[15], full[14], empty[13], 4'b0, count[8:0]}; count is zero-extended when AW<8.
//   2 CTRL   R/W: {thresh[15:8], 5'b0, ovf_clr[2] (W1, self-clearing), flush[1] (W1, self-clearing), en[0]}
//   3 --     R: 0x0000
//  Reset values: wr_ptr=rd_ptr=0, count=0, ovf=0, en=0, thresh=0, d_out=0x0000, irq=0.
//  Pointers: AW+1 bits, wrap modulo 2**(AW+1).
//   count = wr_ptr - rd_ptr (AW+1 bits).
//   empty = count==0; full = count==DEPTH.
//  Push: cap_valid & en & !full -> RAM[wr_ptr[AW-1:0]] <= cap_data; wr_ptr+1.
//  Drop: cap_valid & en & full -> sample dropped, ovf <= 1, which is sticky until ovf_clr or flush.
//  cap_valid while !en: ignored, no ovf.
//  Pop: cs & rd & addr[2:1]==0 & !empty.
//   RAM port B reads rd_ptr in the same cycle; d_out = head word on the next clk; rd_ptr+1.
//  Pop when empty: d_out <= 0x0000, pointers unchanged, no flag.
//  Read latency for every register: 1 clk after the cs&rd cycle. d_out holds its value until the next read.
//  Simultaneous push and pop: both take effect and count is unchanged.
//   Pop at count==1 with push: returns the old head; the new word remains.
//   Push at full with pop: push is still dropped (full is evaluated pre-cycle) and ovf sets.
//  Flush (write CTRL bit1=1): next clk rd_ptr<=wr_ptr<=0, ovf<=0.
//   Flush beats a same-cycle push or pop. en and thresh take the written value.
//  cs&rd&cs&wr same cycle: write has priority; d_out keeps its old value.
//  irq is registered: it reflects count after the current cycle's updates, 1 clk later.
//  Asynchronous reset mid-operation: all state returns to reset values immediately. RAM contents are don't-care.
// STRUCTURE
//  Shared include dpram_capture_defs.vh holds:
//   register offsets REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2;
//   CTRL bit positions; STATUS bit positions.
//  Sub-module: reuse the existing dp_ram (port A write: clk_a/en_a/we_a; port B read: clk_b/en_b/re_b).
//   Instantiate with en_a=push, we_a=push, en_b=1, re_b=pop, adr_b=rd_ptr[AW-1:0].
//  Top level: pointer/count logic, register decode, d_out mux register, irq.
// TESTING
//  1 Basic order: en=1; push 0x1111, 0x2222, 0x3333.
//    -> STATUS count=3; three DATA reads return 0x1111, 0x2222, 0x3333; STATUS then shows empty=1, count=0.
//  2 Fill and overflow (AW=4): push 17 words 0x0000..0x0010.
//    -> full=1, ovf=1, count=16; reads return 0x0000..0x000F; 0x0010 is lost; ovf stays 1 until ovf_clr, then 0.
//  3 Empty pop: read DATA with empty=1.
//    -> d_out=0x0000; count stays 0; next push 0xABCD then read returns 0xABCD.
//  4 Simultaneous push and pop at count=1 (head 0x0001): push 0x0002 in the pop cycle.
//    -> d_out=0x0001; count=1; next read returns 0x0002.
//  5 Pointer wrap (AW=4): 40 interleaved push/pop pairs with values 0..39.
//    -> every read matches in order; count never exceeds 1; no ovf.
//  6 Flush and irq: thresh=4; push 4 words.
//    -> irq=1 one clk after the 4th push. Write CTRL flush=1, en=1, thresh=4 -> count=0, irq=0, ovf=0.
//    Assert reset mid-stream -> d_out=0, empty=1, en=0 immediately.

Source files
------------

// File: rtl/peripheral_dpram_capture_pkg.sv
// Shared register map, bit positions and register-select type for the capture buffer peripheral.
package peripheral_dpram_capture_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;
  localparam int CTRL_TH_LSB  = 8;
  localparam int CTRL_TH_W    = 8;

  // STATUS bit positions
  localparam int ST_OVF   = 15;
  localparam int ST_FULL  = 14;
  localparam int ST_EMPTY = 13;
  localparam int ST_CNT_W = 9;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: port A synchronous write, port B registered read.
// dat_b holds its value on cycles without a read strobe.
module dp_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk_a,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] adr_a,
  input  logic [DW-1:0] dat_a,
  input  logic          clk_b,
  input  logic          en_b,
  input  logic          re_b,
  input  logic [AW-1:0] adr_b,
  output logic [DW-1:0] dat_b
);

  logic [DW-1:0] mem [2**AW];

  // port A write
  always_ff @(posedge clk_a) begin
    if (en_a && we_a) mem[adr_a] <= dat_a;
  end

  // port B registered read
  always_ff @(posedge clk_b) begin
    if (en_b && re_b) dat_b <= mem[adr_b];
  end

endmodule

// File: rtl/peripheral_dpram_capture.sv
// Capture buffer peripheral: a producer pushes samples on port A, the CPU bus pops
// them through the DATA register and sees occupancy/overflow in STATUS.
module peripheral_dpram_capture
  import peripheral_dpram_capture_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic        cap_valid,
  input  logic [15:0] cap_data,
  output logic        irq
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [AW:0]  wr_ptr, rd_ptr, count, wr_ptr_nx, rd_ptr_nx, count_nx;
  logic         ovf, en, en_nx;
  logic [7:0]   thresh, thresh_nx;
  logic         empty, full;
  logic         bus_rd, bus_wr, ctrl_wr, flush, ovf_clr, push, drop, pop;
  logic [15:0]  status, ctrl_rd, d_reg, ram_q;
  logic         sel_ram;
  reg_e         reg_sel;
  logic         unused;

  assign unused  = ^{addr[15:3], addr[0], d_in[7:3]};

  assign reg_sel = reg_e'(addr[2:1]);
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);

  // write wins over a same-cycle read, so a read strobe alongside wr does nothing
  assign bus_wr  = cs & wr;
  assign bus_rd  = cs & rd & ~wr;
  assign ctrl_wr = bus_wr & (reg_sel == REG_CTRL);
  assign flush   = ctrl_wr & d_in[CTRL_FLUSH];
  assign ovf_clr = ctrl_wr & d_in[CTRL_OVF_CLR];

  // full/empty are pre-cycle, so a pop does not make room for a same-cycle push
  assign push    = cap_valid & en & ~full & ~flush;
  assign drop    = cap_valid & en & full;
  assign pop     = bus_rd & (reg_sel == REG_DATA) & ~empty;

  assign wr_ptr_nx = flush ? '0 : wr_ptr + (AW+1)'(push);
  assign rd_ptr_nx = flush ? '0 : rd_ptr + (AW+1)'(pop);
  assign count_nx  = wr_ptr_nx - rd_ptr_nx;
  assign en_nx     = ctrl_wr ? d_in[CTRL_EN] : en;
  assign thresh_nx = ctrl_wr ? d_in[CTRL_TH_LSB +: CTRL_TH_W] : thresh;

  // read-side views of STATUS and CTRL; self-clearing bits read back as 0
  always_comb begin
    status = '0;
    status[ST_OVF]   = ovf;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_CNT_W-1:0] = ST_CNT_W'(count);
    ctrl_rd = '0;
    ctrl_rd[CTRL_TH_LSB +: CTRL_TH_W] = thresh;
    ctrl_rd[CTRL_EN] = en;
  end

  dp_ram #(.AW(AW), .DW(16)) u_ram (
    .clk_a (clk),
    .en_a  (push),
    .we_a  (push),
    .adr_a (wr_ptr[AW-1:0]),
    .dat_a (cap_data),
    .clk_b (clk),
    .en_b  (1'b1),
    .re_b  (pop),
    .adr_b (rd_ptr[AW-1:0]),
    .dat_b (ram_q)
  );

  // pointers, control register, sticky overflow and registered irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      en     <= 1'b0;
      thresh <= '0;
      irq    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      en     <= en_nx;
      thresh <= thresh_nx;
      // a drop in the same cycle as ovf_clr keeps the flag; flush always clears
      if (flush)        ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      irq <= en_nx && (16'(count_nx) >= 16'(thresh_nx));
    end
  end

  // read data register; a DATA pop routes the RAM's registered output instead
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg   <= '0;
      sel_ram <= 1'b0;
    end else if (bus_rd) begin
      sel_ram <= 1'b0;
      d_reg   <= '0;
      case (reg_sel)
        REG_DATA:   sel_ram <= ~empty;
        REG_STATUS: d_reg   <= status;
        REG_CTRL:   d_reg   <= ctrl_rd;
        default:    d_reg   <= '0;
      endcase
    end
  end

  assign d_out = sel_ram ? ram_q : d_reg;

endmodule

// File: tb/tb_peripheral_dpram_capture.sv
// Directed bench for peripheral_dpram_capture (AW=4) with a queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_peripheral_dpram_capture;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, d_in = '0;
  logic [15:0] d_out;
  logic        cap_valid = 1'b0;
  logic [15:0] cap_data = '0;
  logic        irq;

  int tests = 0;
  int fails = 0;

  peripheral_dpram_capture #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_in(d_in),
    .d_out(d_out), .cap_valid(cap_valid), .cap_data(cap_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // reference model: FIFO as a queue, registers as plain variables
  logic [15:0] q[$];
  logic        m_ovf = 1'b0, m_en = 1'b0, m_irq = 1'b0;
  logic [7:0]  m_th = '0;
  logic [15:0] m_dout = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_en = 1'b0; m_th = '0; m_dout = '0; m_irq = 1'b0;
    end else begin
      automatic bit          wrc  = cs && wr;
      automatic bit          rdc  = cs && rd && !wr;
      automatic int          sel  = int'(addr[2:1]);
      automatic int          n    = q.size();
      automatic bit          fl0  = (n == DEPTH);
      automatic bit          flush = wrc && sel == 2 && d_in[1];
      automatic logic [15:0] st   = {m_ovf, fl0, (n == 0), 4'b0, 9'(n)};
      automatic logic [15:0] ct   = {m_th, 7'b0, m_en};
      automatic bit          do_push = cap_valid && m_en && !fl0 && !flush;
      automatic bit          do_drop = cap_valid && m_en && fl0;
      if (rdc) begin
        case (sel)
          0: m_dout = (n > 0) ? q.pop_front() : 16'h0000;
          1: m_dout = st;
          2: m_dout = ct;
          default: m_dout = 16'h0000;
        endcase
      end
      if (do_push) q.push_back(cap_data);
      if (do_drop) m_ovf = 1'b1;
      else if (wrc && sel == 2 && d_in[2]) m_ovf = 1'b0;
      if (flush) begin q.delete(); m_ovf = 1'b0; end
      if (wrc && sel == 2) begin m_en = d_in[0]; m_th = d_in[15:8]; end
      m_irq = m_en && (q.size() >= int'(m_th));
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_dout", d_out, m_dout);
    chk("model_irq", {15'b0, irq}, {15'b0, m_irq});
  end

  task automatic push(input logic [15:0] v);
    cap_valid = 1'b1; cap_data = v;
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = {13'b0, a, 1'b0};
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = {13'b0, a, 1'b0}; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    @(negedge clk);
    chk("reset_dout", d_out, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, v); chk("reset_status", v, 16'h2000);
    rd_reg(2'd2, v); chk("reset_ctrl", v, 16'h0000);

    // 1 basic order
    wr_reg(2'd2, 16'h0001);
    push(16'h1111); push(16'h2222); push(16'h3333);
    rd_reg(2'd1, v); chk("t1_status3", v, 16'h0003);
    rd_reg(2'd0, v); chk("t1_rd0", v, 16'h1111);
    rd_reg(2'd0, v); chk("t1_rd1", v, 16'h2222);
    rd_reg(2'd0, v); chk("t1_rd2", v, 16'h3333);
    rd_reg(2'd1, v); chk("t1_status0", v, 16'h2000);

    // 2 fill and overflow
    for (int i = 0; i < 17; i++) push(16'(i));
    rd_reg(2'd1, v); chk("t2_full_ovf", v, 16'hC010);
    for (int i = 0; i < 16; i++) begin
      rd_reg(2'd0, v); chk("t2_drain", v, 16'(i));
    end
    rd_reg(2'd1, v); chk("t2_ovf_sticky", v, 16'hA000);
    wr_reg(2'd2, 16'h0005);
    rd_reg(2'd1, v); chk("t2_ovf_clr", v, 16'h2000);

    // 3 empty pop
    rd_reg(2'd0, v); chk("t3_empty_pop", v, 16'h0000);
    rd_reg(2'd1, v); chk("t3_status", v, 16'h2000);
    push(16'hABCD);
    rd_reg(2'd0, v); chk("t3_abcd", v, 16'hABCD);

    // 4 simultaneous push and pop at count 1
    push(16'h0001);
    cap_valid = 1'b1; cap_data = 16'h0002;
    rd_reg(2'd0, v);
    cap_valid = 1'b0;
    chk("t4_old_head", v, 16'h0001);
    rd_reg(2'd1, v); chk("t4_count1", v, 16'h0001);
    rd_reg(2'd0, v); chk("t4_new", v, 16'h0002);

    // 5 pointer wrap
    for (int i = 0; i < 40; i++) begin
      push(16'(i));
      rd_reg(2'd0, v); chk("t5_wrap", v, 16'(i));
    end
    rd_reg(2'd1, v); chk("t5_status", v, 16'h2000);

    // 6 threshold irq, flush, async reset
    wr_reg(2'd2, 16'h0401);
    chk("t6_irq_low", {15'b0, irq}, 16'h0000);
    push(16'h0A01); push(16'h0A02); push(16'h0A03);
    chk("t6_irq_3", {15'b0, irq}, 16'h0000);
    push(16'h0A04);
    chk("t6_irq_4", {15'b0, irq}, 16'h0001);
    wr_reg(2'd2, 16'h0403);
    chk("t6_irq_flush", {15'b0, irq}, 16'h0000);
    rd_reg(2'd1, v); chk("t6_flush_status", v, 16'h2000);
    rd_reg(2'd2, v); chk("t6_ctrl", v, 16'h0401);
    push(16'h5A5A); push(16'h1234);
    rd_reg(2'd0, v); chk("t6_pre_reset", v, 16'h5A5A);
    cap_valid = 1'b1; cap_data = 16'h7777;
    #2 reset = 1'b1;
    #1 chk("t6_reset_dout", d_out, 16'h0000);
    chk("t6_reset_irq", {15'b0, irq}, 16'h0000);
    cap_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, v); chk("t6_post_status", v, 16'h2000);
    rd_reg(2'd2, v); chk("t6_post_ctrl", v, 16'h0000);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
